// File: rtl/seg_scan4.sv
// seg_scan4: four-digit multiplexed seven-segment scan controller with frame-synchronous value updates
module seg_scan4 #(
  parameter int PRESCALE = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  output logic [1:0]  sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        blank,
  output logic        frame_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  logic [CW-1:0] cnt;
  logic [15:0] disp_val, pend_val;
  logic [3:0] disp_dp, pend_dp, nib;
  logic [6:0] glyph;
  logic pend, tick, wrap, xfer;
  assign tick = en && cnt == LAST;
  assign wrap = tick && sel == 2'd3;
  assign xfer = wrap || !en;
  // prescaler, digit index, frame pulse and the pending/display update path
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sel <= '0;
      frame_done <= 1'b0;
      disp_val <= '0;
      disp_dp <= '0;
      pend_val <= '0;
      pend_dp <= '0;
      pend <= 1'b0;
    end else begin
      cnt <= tick ? '0 : en ? cnt + 1'b1 : cnt;
      sel <= tick ? sel + 2'd1 : sel;
      frame_done <= wrap;
      if (xfer) begin
        disp_val <= load ? din : pend ? pend_val : disp_val;
        disp_dp <= load ? dp_in : pend ? pend_dp : disp_dp;
        pend <= 1'b0;
      end else if (load) begin
        pend_val <= din;
        pend_dp <= dp_in;
        pend <= 1'b1;
      end
    end
  end
  // current nibble, leading-zero blanking and decimal point for the selected digit
  always_comb begin
    nib = disp_val[{sel, 2'b00} +: 4];
    blank = BLANK_LZ && (sel == 2'd3 ? disp_val[15:12] == 4'd0 :
                         sel == 2'd2 ? disp_val[15:8] == 8'd0 :
                         sel == 2'd1 ? disp_val[15:4] == 12'd0 : 1'b0);
    dp = disp_dp[sel];
    seg = blank ? 7'h00 : glyph;
  end
  // hex font, segments ordered {g,f,e,d,c,b,a}
  always_comb begin
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end
endmodule
